// File: rtl/uart_log_arbiter_if.sv
// Bundle of the per-source timestamp ports and the logger-side output port.
// The arbiter connects through the master modport, the sources/logger through slave.
interface uart_log_arbiter_if #(
   parameter int N_SRC = 4,
   parameter int ID_W  = 16,
   parameter int TS_W  = 64
);
   localparam int SRC_W = $clog2(N_SRC);

   logic [N_SRC-1:0]      src_valid;
   logic [N_SRC-1:0]      src_ready;
   logic [N_SRC*ID_W-1:0] src_id;
   logic [N_SRC*TS_W-1:0] src_start_ts;
   logic [N_SRC*TS_W-1:0] src_end_ts;

   logic                  out_valid;
   logic                  out_ready;
   logic [ID_W-1:0]       out_id;
   logic [TS_W-1:0]       out_start_ts;
   logic [TS_W-1:0]       out_end_ts;
   logic [TS_W-1:0]       out_delta;
   logic [SRC_W-1:0]      out_src;

   modport master (
      input  src_valid, src_id, src_start_ts, src_end_ts, out_ready,
      output src_ready, out_valid, out_id, out_start_ts, out_end_ts, out_delta, out_src
   );

   modport slave (
      output src_valid, src_id, src_start_ts, src_end_ts, out_ready,
      input  src_ready, out_valid, out_id, out_start_ts, out_end_ts, out_delta, out_src
   );
endinterface

// File: rtl/uart_log_arbiter.sv
// Round-robin arbiter funnelling timestamp events from N_SRC sources into one
// UART logger; captures one event, holds it until the logger accepts it.
module uart_log_arbiter #(
   parameter int N_SRC = 4,
   parameter int ID_W  = 16,
   parameter int TS_W  = 64,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_log_arbiter_if.master bus,
   output logic [CNT_W-1:0]   evt_cnt,
   output logic [15:0]        neg_delta_cnt
);
   localparam int SRC_W = $clog2(N_SRC);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t             state_q;
   logic [SRC_W-1:0]   last_grant_q;
   logic               out_valid_q;
   logic [ID_W-1:0]    id_q;
   logic [TS_W-1:0]    start_q;
   logic [TS_W-1:0]    end_q;
   logic [TS_W-1:0]    delta_q;
   logic [SRC_W-1:0]   src_q;
   logic [CNT_W-1:0]   evt_cnt_q;
   logic [15:0]        neg_cnt_q;

   logic               grant_hit_d;
   logic [SRC_W-1:0]   grant_idx_d;
   logic [N_SRC-1:0]   src_ready_d;
   logic [ID_W-1:0]    cap_id_d;
   logic [TS_W-1:0]    cap_start_d;
   logic [TS_W-1:0]    cap_end_d;
   logic [TS_W-1:0]    cap_delta_d;
   logic               cap_neg_d;

   // Search starts one past the last winner so every source gets a turn.
   always_comb begin
      int cand;
      grant_hit_d = 1'b0;
      grant_idx_d = '0;
      cand        = 0;
      for (int k = 1; k <= N_SRC; k++) begin
         cand = (int'(last_grant_q) + k) % N_SRC;
         if (!grant_hit_d && bus.src_valid[cand[SRC_W-1:0]]) begin
            grant_hit_d = 1'b1;
            grant_idx_d = cand[SRC_W-1:0];
         end
      end
   end

   always_comb begin
      src_ready_d = '0;
      if (rst_n && state_q == IDLE && grant_hit_d)
         src_ready_d[grant_idx_d] = 1'b1;
   end

   always_comb begin
      cap_id_d    = bus.src_id[grant_idx_d*ID_W +: ID_W];
      cap_start_d = bus.src_start_ts[grant_idx_d*TS_W +: TS_W];
      cap_end_d   = bus.src_end_ts[grant_idx_d*TS_W +: TS_W];
      cap_neg_d   = cap_end_d < cap_start_d;
      cap_delta_d = cap_neg_d ? '0 : (cap_end_d - cap_start_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= SRC_W'(N_SRC - 1);
         out_valid_q  <= 1'b0;
         id_q         <= '0;
         start_q      <= '0;
         end_q        <= '0;
         delta_q      <= '0;
         src_q        <= '0;
         evt_cnt_q    <= '0;
         neg_cnt_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_hit_d) begin
                  id_q         <= cap_id_d;
                  start_q      <= cap_start_d;
                  end_q        <= cap_end_d;
                  delta_q      <= cap_delta_d;
                  src_q        <= grant_idx_d;
                  last_grant_q <= grant_idx_d;
                  evt_cnt_q    <= evt_cnt_q + 1'b1;
                  if (cap_neg_d && neg_cnt_q != 16'hFFFF)
                     neg_cnt_q <= neg_cnt_q + 16'd1;
                  out_valid_q  <= 1'b1;
                  state_q      <= HOLD;
               end
            end
            HOLD: begin
               // Handshake cycle never accepts a new source; IDLE does next cycle.
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.src_ready    = src_ready_d;
   assign bus.out_valid    = out_valid_q;
   assign bus.out_id       = id_q;
   assign bus.out_start_ts = start_q;
   assign bus.out_end_ts   = end_q;
   assign bus.out_delta    = delta_q;
   assign bus.out_src      = src_q;
   assign evt_cnt          = evt_cnt_q;
   assign neg_delta_cnt    = neg_cnt_q;
endmodule

// File: tb/tb_uart_log_arbiter.sv
// Directed scenarios plus a randomized phase, each cycle compared against an
// event-level reference model of the round-robin logger arbiter.
module tb_uart_log_arbiter;
   localparam int N   = 4;
   localparam int IDW = 16;
   localparam int TSW = 64;
   localparam int CW  = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] evt_cnt;
   logic [15:0]   neg_delta_cnt;
   int            total = 0;
   int            bad = 0;

   uart_log_arbiter_if #(.N_SRC(N), .ID_W(IDW), .TS_W(TSW)) bus ();

   uart_log_arbiter #(.N_SRC(N), .ID_W(IDW), .TS_W(TSW), .CNT_W(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus.master),
      .evt_cnt       (evt_cnt),
      .neg_delta_cnt (neg_delta_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: one pending-event slot, a rotating priority pointer, counters.
   bit          m_hold;
   int          m_ptr;
   logic [15:0] m_id;
   logic [63:0] m_start, m_end, m_delta;
   int          m_src;
   int          m_evt;
   int          m_neg;
   int          grant_log[$];

   function automatic int pick(logic [N-1:0] v, int ptr);
      for (int k = 1; k <= N; k++)
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_hold = 0; m_ptr = N - 1; m_id = '0; m_start = '0; m_end = '0;
      m_delta = '0; m_src = 0; m_evt = 0; m_neg = 0;
   endtask

   task automatic set_src(int i, logic [15:0] id, logic [63:0] s, logic [63:0] e);
      bus.src_id[i*IDW +: IDW]       = id;
      bus.src_start_ts[i*TSW +: TSW] = s;
      bus.src_end_ts[i*TSW +: TSW]   = e;
   endtask

   // One clock: check combinational ready, clock, advance model, check registers.
   task automatic step(string tag);
      int          g;
      logic [N-1:0] er;
      logic [63:0] s, e;
      #1;
      g  = m_hold ? -1 : pick(bus.src_valid, m_ptr);
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk({tag, "_ready"}, 128'(bus.src_ready), 128'(er));
      @(posedge clk);
      if (g >= 0) begin
         s = bus.src_start_ts[g*TSW +: TSW];
         e = bus.src_end_ts[g*TSW +: TSW];
         m_id = bus.src_id[g*IDW +: IDW];
         m_start = s; m_end = e; m_src = g; m_ptr = g;
         m_hold = 1; m_evt++;
         if (e < s) begin
            m_delta = '0;
            if (m_neg < 65535) m_neg++;
         end else begin
            m_delta = e - s;
         end
         grant_log.push_back(g);
      end else if (m_hold && bus.out_ready) begin
         m_hold = 0;
      end
      #1;
      chk({tag, "_valid"}, 128'(bus.out_valid), 128'(m_hold));
      if (m_hold) begin
         chk({tag, "_id"},    128'(bus.out_id),       128'(m_id));
         chk({tag, "_start"}, 128'(bus.out_start_ts), 128'(m_start));
         chk({tag, "_end"},   128'(bus.out_end_ts),   128'(m_end));
         chk({tag, "_delta"}, 128'(bus.out_delta),    128'(m_delta));
         chk({tag, "_src"},   128'(bus.out_src),      128'(m_src));
      end
      chk({tag, "_evt"}, 128'(evt_cnt),       128'(m_evt));
      chk({tag, "_neg"}, 128'(neg_delta_cnt), 128'(m_neg));
      $display("step %s: valid=%0b ready=%b src=%0d delta=%0d evt=%0d neg=%0d",
               tag, bus.out_valid, bus.src_ready, bus.out_src, bus.out_delta, evt_cnt, neg_delta_cnt);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_valid", 128'(bus.out_valid), 128'(0));
      chk("rst_ready", 128'(bus.src_ready), 128'(0));
      chk("rst_delta", 128'(bus.out_delta), 128'(0));
      chk("rst_evt",   128'(evt_cnt),       128'(0));
      chk("rst_neg",   128'(neg_delta_cnt), 128'(0));
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      bus.src_valid = '0; bus.src_id = '0; bus.src_start_ts = '0; bus.src_end_ts = '0;
      bus.out_ready = 1'b0;
      do_reset();

      // Single event under 20 cycles of logger backpressure
      set_src(2, 16'h0042, 64'd100, 64'd350);
      bus.src_valid = 4'b0100;
      step("t1_acc");
      bus.src_valid = '0;
      for (int i = 0; i < 20; i++) step("t1_hold");
      chk("t1_src",   128'(bus.out_src),   128'(2));
      chk("t1_delta", 128'(bus.out_delta), 128'(250));
      chk("t1_id",    128'(bus.out_id),    128'(16'h0042));
      chk("t1_evt",   128'(evt_cnt),       128'(1));
      bus.out_ready = 1'b1;
      step("t1_hs");

      // All sources valid: rotation 0,1,2,3,0,1 at one event per two cycles
      do_reset();
      grant_log.delete();
      for (int i = 0; i < N; i++) set_src(i, 16'(16'h10 + i), 64'(1000 * i), 64'(1000 * i + 7 + i));
      bus.src_valid = 4'b1111;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 12; i++) step("t2");
      chk("t2_ngrants", 128'(grant_log.size()), 128'(6));
      for (int k = 0; k < 6 && k < grant_log.size(); k++)
         chk("t2_order", 128'(grant_log[k]), 128'(k % N));

      // Negative delta clamps to zero and is counted
      bus.src_valid = 4'b0010;
      set_src(1, 16'h0777, 64'd500, 64'd200);
      bus.out_ready = 1'b0;
      step("t3_acc");
      bus.src_valid = '0;
      chk("t3_delta", 128'(bus.out_delta), 128'(0));
      chk("t3_neg",   128'(neg_delta_cnt), 128'(1));
      chk("t3_valid", 128'(bus.out_valid), 128'(1));

      // src0 withdraws while HOLD blocks; only src3 is granted afterwards
      set_src(3, 16'h0333, 64'd10, 64'd20);
      bus.src_valid = 4'b1001;
      step("t4_both");
      bus.src_valid = 4'b1000;
      step("t4_drop");
      bus.out_ready = 1'b1;
      step("t4_hs");
      step("t4_acc");
      bus.src_valid = '0;
      chk("t4_grant", 128'(grant_log[grant_log.size()-1]), 128'(3));
      step("t4_hs2");

      // Asynchronous reset in the middle of HOLD
      bus.out_ready = 1'b0;
      bus.src_valid = 4'b0100;
      step("t5_acc");
      bus.src_valid = '0;
      step("t5_hold");
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      chk("t5_valid", 128'(bus.out_valid), 128'(0));
      chk("t5_evt",   128'(evt_cnt),       128'(0));
      chk("t5_neg",   128'(neg_delta_cnt), 128'(0));
      bus.src_valid = 4'b0110;
      bus.out_ready = 1'b1;
      #1;
      chk("t5_rdy_in_rst", 128'(bus.src_ready), 128'(0));
      @(posedge clk);
      #1 rst_n = 1'b1;
      grant_log.delete();
      step("t5_acc2");
      chk("t5_first", 128'(bus.out_src), 128'(1));
      bus.src_valid = '0;
      step("t5_hs");

      // Randomized traffic against the model
      for (int i = 0; i < 300; i++) begin
         bus.src_valid = 4'($urandom);
         for (int s = 0; s < N; s++)
            set_src(s, 16'($urandom), {32'($urandom_range(0, 3)), $urandom},
                    {32'($urandom_range(0, 3)), $urandom});
         bus.out_ready = ($urandom_range(0, 3) != 0);
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
